// File: rtl/abr_masked_sub_sched.sv
// Round-robin scheduler sharing one masked Boolean subtractor pipeline among NREQ requesters.
// Tags each operation through the fixed-latency pipeline and returns results to the issuer.
module abr_masked_sub_sched #(
  parameter int WIDTH   = 8,
  parameter int NREQ    = 2,
  parameter int LATENCY = 9
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              zeroize,
  input  logic [NREQ-1:0]                   req_valid_i,
  output logic [NREQ-1:0]                   req_ready_o,
  input  logic [NREQ-1:0]                   req_sub_i,
  input  logic [NREQ-1:0][WIDTH-1:0][1:0]   req_x_i,
  input  logic [NREQ-1:0][WIDTH-1:0][1:0]   req_y_i,
  input  logic                              rnd_valid_i,
  input  logic [WIDTH-1:0]                  rnd_i,
  output logic                              rnd_ready_o,
  output logic [WIDTH-1:0][1:0]             sub_x_o,
  output logic [WIDTH-1:0][1:0]             sub_y_o,
  output logic                              sub_sub_o,
  output logic [WIDTH-1:0]                  sub_rnd_o,
  input  logic [WIDTH-1:0][1:0]             sub_s_i,
  output logic [NREQ-1:0]                   rsp_valid_o,
  output logic [WIDTH-1:0][1:0]             rsp_s_o,
  output logic                              busy_o,
  output logic                              rnd_starve_o
);

  localparam int TW = $clog2(NREQ);
  localparam int CW = $clog2(LATENCY + 2);
  localparam int unsigned NR = NREQ;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                    state, state_next;
  logic [CW-1:0]             cnt, cnt_next;
  logic [TW-1:0]             rr_ptr, rr_next;
  logic                      grant;
  logic [TW-1:0]             gidx;
  logic [LATENCY:0]          pipe_v;
  logic [LATENCY:0][TW-1:0]  pipe_tag;
  logic                      resp;
  logic [WIDTH-1:0][1:0]     sel_y;

  // First eligible requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    logic [TW-1:0] cand;
    grant       = 1'b0;
    gidx        = '0;
    cand        = '0;
    req_ready_o = '0;
    if (rnd_valid_i && !zeroize) begin
      for (int unsigned i = 0; i < NR; i++) begin
        cand = TW'((32'(rr_ptr) + i) % NR);
        if (!grant && req_valid_i[cand]) begin
          grant = 1'b1;
          gidx  = cand;
        end
      end
    end
    if (grant) req_ready_o[gidx] = 1'b1;
  end

  always_comb begin
    if (gidx == TW'(NREQ - 1)) rr_next = '0;
    else                       rr_next = gidx + TW'(1);
  end

  // Subtraction becomes x + ~y + 1: complementing one share complements the unmasked y.
  always_comb begin
    sel_y = req_y_i[gidx];
    for (int unsigned i = 0; i < WIDTH; i++)
      sel_y[i][0] = req_y_i[gidx][i][0] ^ req_sub_i[gidx];
  end

  assign resp        = pipe_v[LATENCY];
  assign busy_o      = (state == BUSY);
  assign rnd_ready_o = grant | busy_o;
  assign sub_rnd_o   = rnd_i;

  always_comb begin
    rsp_valid_o = '0;
    if (resp) rsp_valid_o[pipe_tag[LATENCY]] = 1'b1;
    rsp_s_o = resp ? sub_s_i : '0;
  end

  always_comb begin
    cnt_next   = cnt;
    state_next = state;
    case ({grant, resp})
      2'b10:   cnt_next = cnt + CW'(1);
      2'b01:   cnt_next = cnt - CW'(1);
      default: cnt_next = cnt;
    endcase
    case (state)
      IDLE: if (grant) state_next = BUSY;
      BUSY: if (cnt_next == '0 && !grant) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       state <= IDLE;
    else if (zeroize) state <= IDLE;
    else              state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_x_o      <= '0;
      sub_y_o      <= '0;
      sub_sub_o    <= 1'b0;
      pipe_v       <= '0;
      pipe_tag     <= '0;
      rr_ptr       <= '0;
      cnt          <= '0;
      rnd_starve_o <= 1'b0;
    end else if (zeroize) begin
      sub_x_o      <= '0;
      sub_y_o      <= '0;
      sub_sub_o    <= 1'b0;
      pipe_v       <= '0;
      pipe_tag     <= '0;
      rr_ptr       <= '0;
      cnt          <= '0;
      rnd_starve_o <= 1'b0;
    end else begin
      sub_x_o      <= grant ? req_x_i[gidx] : '0;
      sub_y_o      <= grant ? sel_y : '0;
      sub_sub_o    <= grant & req_sub_i[gidx];
      pipe_v       <= {pipe_v[LATENCY-1:0], grant};
      pipe_tag     <= {pipe_tag[LATENCY-1:0], gidx};
      if (grant) rr_ptr <= rr_next;
      cnt          <= cnt_next;
      rnd_starve_o <= rnd_starve_o | (rnd_ready_o & ~rnd_valid_i);
    end
  end

endmodule

// File: tb/tb_abr_masked_sub_sched.sv
// Scoreboard bench for abr_masked_sub_sched with a behavioural masked-subtractor model.
module tb_abr_masked_sub_sched;

  localparam int W = 8;
  localparam int N = 2;
  localparam int L = 9;

  typedef logic [W-1:0][1:0] sh_t;
  typedef struct { logic sub; logic [W-1:0] x; logic [W-1:0] y; logic [W-1:0] exp; } vec_t;
  typedef struct { int k; logic [W-1:0] exp; int cyc; } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 zeroize = 1'b0;
  logic [N-1:0]         req_valid_i = '0;
  logic [N-1:0]         req_ready_o;
  logic [N-1:0]         req_sub_i = '0;
  logic [N-1:0][W-1:0][1:0] req_x_i = '0;
  logic [N-1:0][W-1:0][1:0] req_y_i = '0;
  logic                 rnd_valid_i = 1'b1;
  logic [W-1:0]         rnd_i = '0;
  logic                 rnd_ready_o;
  sh_t                  sub_x_o, sub_y_o, sub_s_i, rsp_s_o;
  logic                 sub_sub_o;
  logic [W-1:0]         sub_rnd_o;
  logic [N-1:0]         rsp_valid_o;
  logic                 busy_o, rnd_starve_o;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t sbq[$];
  vec_t vq[N][$];
  int   glog[$];

  abr_masked_sub_sched #(.WIDTH(W), .NREQ(N), .LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .zeroize(zeroize),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_sub_i(req_sub_i),
    .req_x_i(req_x_i), .req_y_i(req_y_i),
    .rnd_valid_i(rnd_valid_i), .rnd_i(rnd_i), .rnd_ready_o(rnd_ready_o),
    .sub_x_o(sub_x_o), .sub_y_o(sub_y_o), .sub_sub_o(sub_sub_o), .sub_rnd_o(sub_rnd_o),
    .sub_s_i(sub_s_i), .rsp_valid_o(rsp_valid_o), .rsp_s_o(rsp_s_o),
    .busy_o(busy_o), .rnd_starve_o(rnd_starve_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rnd_i <= W'($urandom);

  function automatic logic [W-1:0] unm(sh_t v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[i][0] ^ v[i][1];
    return r;
  endfunction

  function automatic sh_t msk(logic [W-1:0] v);
    sh_t r;
    logic [W-1:0] m;
    m = W'($urandom);
    for (int i = 0; i < W; i++) r[i] = {m[i], v[i] ^ m[i]};
    return r;
  endfunction

  // Behavioural subtractor: unmasks, adds with carry-in, remasks, delays L cycles.
  logic [W-1:0] mdl_v [L];
  logic [W-1:0] mdl_m [L];
  always @(posedge clk) begin
    mdl_v[0] <= unm(sub_x_o) + unm(sub_y_o) + {{(W-1){1'b0}}, sub_sub_o};
    mdl_m[0] <= W'($urandom);
    for (int i = 1; i < L; i++) begin
      mdl_v[i] <= mdl_v[i-1];
      mdl_m[i] <= mdl_m[i-1];
    end
  end
  always_comb
    for (int i = 0; i < W; i++) sub_s_i[i] = {mdl_m[L-1][i], mdl_v[L-1][i] ^ mdl_m[L-1][i]};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_push(int k, logic [W-1:0] e);
    exp_t t;
    t.k = k; t.exp = e; t.cyc = cyc;
    sbq.push_back(t);
  endtask

  // Monitor: every response strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && rsp_valid_o != '0) begin
      if (sbq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid=0x%0h, expected none", rsp_valid_o);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rsp_valid", 32'(rsp_valid_o), 32'(1 << e.k));
        chk("rsp_value", 32'(unm(rsp_s_o)), 32'(e.exp));
        chk("rsp_latency", 32'(cyc - e.cyc), 32'(L + 1));
      end
    end
  end

  task automatic apply(int k, vec_t v, logic vld);
    req_valid_i[k] = vld;
    req_sub_i[k]   = vld & v.sub;
    req_x_i[k]     = vld ? msk(v.x) : '0;
    req_y_i[k]     = vld ? msk(v.y) : '0;
  endtask

  task automatic load_fronts();
    vec_t z;
    z = '{1'b0, '0, '0, '0};
    for (int k = 0; k < N; k++)
      if (vq[k].size() > 0) apply(k, vq[k][0], 1'b1);
      else                  apply(k, z, 1'b0);
  endtask

  task automatic run_ops(int max_cyc);
    int n;
    n = 0;
    load_fronts();
    while ((vq[0].size() > 0 || vq[1].size() > 0) && n < max_cyc) begin
      @(negedge clk);
      for (int k = 0; k < N; k++)
        if (req_valid_i[k] && req_ready_o[k]) begin
          sb_push(k, vq[k][0].exp);
          glog.push_back(k);
          void'(vq[k].pop_front());
        end
      @(posedge clk); #1;
      load_fronts();
      n++;
    end
    chk("run_ops_done", 32'(vq[0].size() + vq[1].size()), 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_o || sbq.size() > 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(busy_o || sbq.size() > 0), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic s, logic [W-1:0] x, logic [W-1:0] y, logic [W-1:0] e);
    vec_t v;
    v.sub = s; v.x = x; v.y = y; v.exp = e;
    return v;
  endfunction

  initial begin
    vec_t v;
    // Reset state
    idle_cycles(2);
    #2;
    chk("rst_sub_x", 32'(sub_x_o), 32'd0);
    chk("rst_sub_y", 32'(sub_y_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_rnd_ready", 32'(rnd_ready_o), 32'd0);
    chk("rst_req_ready", 32'(req_ready_o), 32'd0);
    chk("rst_starve", 32'(rnd_starve_o), 32'd0);
    rst_n = 1'b1;
    idle_cycles(2);

    // Single subtract on requester 0, then add-wrap and sub-wrap on requester 1
    vq[0].push_back(mk(1'b1, 8'h5A, 8'h23, 8'h37));
    run_ops(20);
    wait_idle();
    vq[1].push_back(mk(1'b0, 8'hF0, 8'h20, 8'h10));
    vq[1].push_back(mk(1'b1, 8'h10, 8'h20, 8'hF0));
    run_ops(20);
    wait_idle();

    // Both requesters contending: strict alternation starting at 0
    glog.delete();
    vq[0].push_back(mk(1'b1, 8'h11, 8'h01, 8'h10));
    vq[0].push_back(mk(1'b0, 8'h80, 8'h80, 8'h00));
    vq[0].push_back(mk(1'b1, 8'h00, 8'h01, 8'hFF));
    vq[1].push_back(mk(1'b0, 8'h12, 8'h34, 8'h46));
    vq[1].push_back(mk(1'b1, 8'h55, 8'h55, 8'h00));
    vq[1].push_back(mk(1'b0, 8'hFF, 8'h01, 8'h00));
    run_ops(20);
    chk("alt_grants", 32'(glog.size()), 32'd6);
    for (int i = 0; i < glog.size(); i++) chk("alt_order", 32'(glog[i]), 32'(i % 2));
    wait_idle();

    // Randomness dropped while operations are in flight
    vq[0].push_back(mk(1'b0, 8'h01, 8'h02, 8'h03));
    vq[0].push_back(mk(1'b0, 8'h40, 8'h40, 8'h80));
    vq[0].push_back(mk(1'b1, 8'h03, 8'h05, 8'hFE));
    run_ops(20);
    rnd_valid_i = 1'b0;
    v = mk(1'b0, 8'h03, 8'h04, 8'h07);
    apply(1, v, 1'b1);
    @(negedge clk);
    chk("starve_no_grant", 32'(req_ready_o), 32'd0);
    chk("starve_rnd_ready", 32'(rnd_ready_o), 32'd1);
    @(posedge clk); #1;
    rnd_valid_i = 1'b1;
    @(negedge clk);
    chk("starve_set", 32'(rnd_starve_o), 32'd1);
    chk("starve_regrant", 32'(req_ready_o), 32'h2);
    if (req_ready_o[1]) sb_push(1, v.exp);
    @(posedge clk); #1;
    apply(1, v, 1'b0);
    wait_idle();
    chk("starve_sticky", 32'(rnd_starve_o), 32'd1);
    zeroize = 1'b1;
    @(posedge clk); #1;
    zeroize = 1'b0;
    @(negedge clk);
    chk("starve_zeroized", 32'(rnd_starve_o), 32'd0);
    @(posedge clk); #1;

    // Zeroize four cycles after a grant drops the operation
    vq[0].push_back(mk(1'b0, 8'h0A, 8'h0B, 8'h15));
    run_ops(20);
    idle_cycles(3);
    zeroize = 1'b1;
    @(negedge clk);
    sbq.delete();
    @(posedge clk); #1;
    zeroize = 1'b0;
    @(negedge clk);
    chk("zero_busy", 32'(busy_o), 32'd0);
    chk("zero_rsp", 32'(rsp_valid_o), 32'd0);
    idle_cycles(L + 4);
    vq[1].push_back(mk(1'b1, 8'h9C, 8'h1C, 8'h80));
    run_ops(20);
    wait_idle();

    // Asynchronous reset with five operations in flight
    vq[0].push_back(mk(1'b0, 8'h01, 8'h01, 8'h02));
    vq[0].push_back(mk(1'b0, 8'h02, 8'h02, 8'h04));
    vq[0].push_back(mk(1'b0, 8'h03, 8'h03, 8'h06));
    vq[1].push_back(mk(1'b1, 8'h10, 8'h01, 8'h0F));
    vq[1].push_back(mk(1'b1, 8'h20, 8'h01, 8'h1F));
    run_ops(20);
    idle_cycles(1);
    rst_n = 1'b0;
    #1;
    sbq.delete();
    chk("arst_rsp", 32'(rsp_valid_o), 32'd0);
    chk("arst_rsp_s", 32'(rsp_s_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_sub_x", 32'(sub_x_o), 32'd0);
    chk("arst_rnd_ready", 32'(rnd_ready_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycles(L + 5);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
